// File: rtl/panel_keys.sv
// Front-panel conditioner: synchronizes and debounces console keys and switches,
// and turns each key press into one fixed-width pulse behind a one-key interlock.
module panel_keys #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int PULSE_CYCLES    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  raw_keys,
   input  logic [11:0] raw_sr,
   input  logic [2:0]  raw_dfsr,
   input  logic [2:0]  raw_ifsr,
   input  logic        raw_sing_step,
   input  logic        raw_sing_inst,
   output logic        stop,
   output logic        start,
   output logic        load_addr,
   output logic        exam,
   output logic        dep,
   output logic        cont,
   output logic        step,
   output logic [11:0] sr,
   output logic [2:0]  dfsr,
   output logic [2:0]  ifsr,
   output logic        sing_step,
   output logic        sing_inst,
   output logic        key_busy,
   output logic [1:0]  dbg_state
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam int PW = $clog2(PULSE_CYCLES + 1);
   localparam logic [PW-1:0] P_LOAD = PW'(PULSE_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PULSE   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   // Synchronizers are left unreset so a key held through reset is still seen
   // as held the moment reset drops.
   logic [6:0]  r_ksync1, r_ksync2;
   logic [19:0] r_ssync1, r_ssync2;
   logic [19:0] w_sw_raw;

   assign w_sw_raw = {raw_sing_inst, raw_sing_step, raw_ifsr, raw_dfsr, raw_sr};

   always_ff @(posedge clk) begin
      r_ksync1 <= raw_keys;
      r_ksync2 <= r_ksync1;
      r_ssync1 <= w_sw_raw;
      r_ssync2 <= r_ssync1;
   end

   logic [6:0]    r_db;
   logic [CW-1:0] r_kcnt [7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_db <= '0;
         for (int i = 0; i < 7; i++) r_kcnt[i] <= '0;
      end else begin
         for (int i = 0; i < 7; i++) begin
            if (r_ksync2[i] == r_db[i]) begin
               r_kcnt[i] <= '0;
            end else if (r_kcnt[i] == C_LAST) begin
               r_db[i]   <= ~r_db[i];
               r_kcnt[i] <= '0;
            end else begin
               r_kcnt[i] <= r_kcnt[i] + CW'(1);
            end
         end
      end
   end

   // Bank debouncer: a change is the vector differing as it enters the second stage.
   logic [CW-1:0] r_scnt;
   logic [19:0]   r_sw;
   logic          w_sw_change;

   assign w_sw_change = (r_ssync1 != r_ssync2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scnt <= '0;
         r_sw   <= '0;
      end else if (w_sw_change) begin
         r_scnt <= '0;
      end else if (r_scnt == C_LAST) begin
         r_sw <= r_ssync2;
      end else begin
         r_scnt <= r_scnt + CW'(1);
      end
   end

   assign {sing_inst, sing_step, ifsr, dfsr, sr} = r_sw;

   state_t        r_state, w_state_nxt;
   logic [PW-1:0] r_pcnt, w_pcnt_nxt;
   logic [6:0]    r_kout, w_kout_nxt;
   logic [6:0]    w_sel;
   logic          r_busy;

   // Highest bit wins: stop is bit 6, step is bit 0.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < 7; i++) begin
         if (r_db[i]) begin
            w_sel    = '0;
            w_sel[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pcnt_nxt  = r_pcnt;
      w_kout_nxt  = r_kout;
      case (r_state)
         S_IDLE: begin
            if (|r_db) begin
               w_state_nxt = S_PULSE;
               w_pcnt_nxt  = P_LOAD;
               w_kout_nxt  = w_sel;
            end
         end
         S_PULSE: begin
            if (r_pcnt <= PW'(1)) begin
               w_state_nxt = S_RELEASE;
               w_pcnt_nxt  = '0;
               w_kout_nxt  = '0;
            end else begin
               w_pcnt_nxt = r_pcnt - PW'(1);
            end
         end
         S_RELEASE: begin
            // Also require the synchronized contacts low, so a key held through
            // reset (debounced state cleared) cannot re-arm the interlock.
            if ((r_db == 7'd0) && (r_ksync2 == 7'd0)) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_RELEASE;
            w_pcnt_nxt  = '0;
            w_kout_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RELEASE;
         r_pcnt  <= '0;
         r_kout  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_kout  <= w_kout_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   assign {stop, start, load_addr, exam, dep, cont, step} = r_kout;
   assign key_busy  = r_busy;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_panel_keys.sv
// Bench for panel_keys: directed tables and sequences plus random stimulus
// compared every cycle against a window-based reference model.
module tb_panel_keys;

   localparam int D = 4;
   localparam int P = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  raw_keys = '0;
   logic [19:0] raw_sw = '0;

   logic        stop, start, load_addr, exam, dep, cont, step;
   logic [11:0] sr;
   logic [2:0]  dfsr, ifsr;
   logic        sing_step, sing_inst, key_busy;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   panel_keys #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P)) dut (
      .clk(clk), .rst(rst), .raw_keys(raw_keys),
      .raw_sr(raw_sw[11:0]), .raw_dfsr(raw_sw[14:12]), .raw_ifsr(raw_sw[17:15]),
      .raw_sing_step(raw_sw[18]), .raw_sing_inst(raw_sw[19]),
      .stop(stop), .start(start), .load_addr(load_addr), .exam(exam),
      .dep(dep), .cont(cont), .step(step),
      .sr(sr), .dfsr(dfsr), .ifsr(ifsr), .sing_step(sing_step), .sing_inst(sing_inst),
      .key_busy(key_busy), .dbg_state(dbg_state)
   );

   logic [6:0]  keys_out;
   logic [19:0] sw_out;
   assign keys_out = {stop, start, load_addr, exam, dep, cont, step};
   assign sw_out   = {sing_inst, sing_step, ifsr, dfsr, sr};

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: raw history per clock edge; debounce and bank loads are
   // decided by looking at windows of that history.
   logic [6:0]  hk[$];
   logic [19:0] hs[$];
   int          m_n = 0;
   logic [6:0]  m_db = '0;
   logic [6:0]  m_kout = '0;
   logic [19:0] m_sw = '0;
   int          m_left = 0;
   bit          m_armed = 1'b0;
   logic        m_busy = 1'b0;

   always @(posedge clk) begin
      logic [6:0]  ks, hv;
      logic [19:0] a, b;
      int          sz;
      bit          flip, stable, found;
      hk.push_back(raw_keys);
      hs.push_back(raw_sw);
      if (hk.size() > 16) begin
         hk.delete(0);
         hs.delete(0);
      end
      sz = hk.size();
      if (rst) begin
         m_n = 0; m_db = '0; m_kout = '0; m_sw = '0;
         m_left = 0; m_armed = 1'b0; m_busy = 1'b0;
      end else begin
         m_n++;
         ks = hk[sz-3];
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_kout = '0;
         end else if (!m_armed) begin
            if (m_db == 7'd0 && ks == 7'd0) m_armed = 1'b1;
         end else if (m_db != 7'd0) begin
            m_kout = '0;
            found = 1'b0;
            for (int k = 6; k >= 0; k--) begin
               if (m_db[k] && !found) begin
                  m_kout[k] = 1'b1;
                  found = 1'b1;
               end
            end
            m_left  = P;
            m_armed = 1'b0;
         end
         m_busy = !m_armed;
         if (m_n >= D) begin
            for (int k = 0; k < 7; k++) begin
               flip = 1'b1;
               for (int j = 2; j <= D + 1; j++) begin
                  hv = hk[sz-1-j];
                  if (hv[k] == m_db[k]) flip = 1'b0;
               end
               if (flip) m_db[k] = ~m_db[k];
            end
            stable = 1'b1;
            for (int j = 1; j <= D; j++) begin
               a = hs[sz-1-j];
               b = hs[sz-2-j];
               if (a != b) stable = 1'b0;
            end
            if (stable) m_sw = hs[sz-3];
         end
      end
   end

   always @(negedge clk) begin
      check("model", {4'd0, m_kout, m_busy, m_sw}, {4'd0, keys_out, key_busy, sw_out});
   end

   typedef struct {
      logic [6:0]  rk;
      logic [19:0] rsw;
      int          cyc;
      logic [6:0]  exp_seen;
      int          exp_pcyc;
      logic [19:0] exp_sw;
   } vec_t;

   vec_t tbl[9];

   task automatic run_cycles(input int n, output logic [6:0] seen, output int pc);
      seen = '0;
      pc   = 0;
      repeat (n) begin
         @(negedge clk);
         seen = seen | keys_out;
         if (|keys_out) pc++;
      end
      #2;
   endtask

   initial begin
      logic [6:0] seen;
      int         pc, h, r, left;
      bit         got;

      tbl[0] = '{7'b0000100, 20'h0, 20, 7'b0000100, 3, 20'h0};
      tbl[1] = '{7'b0000000, 20'h0, 12, 7'b0000000, 0, 20'h0};
      tbl[2] = '{7'b1000010, 20'h0, 15, 7'b1000000, 3, 20'h0};
      tbl[3] = '{7'b0000010, 20'h0, 15, 7'b0000000, 0, 20'h0};
      tbl[4] = '{7'b0000000, 20'h0, 12, 7'b0000000, 0, 20'h0};
      tbl[5] = '{7'b0000010, 20'h0, 15, 7'b0000010, 3, 20'h0};
      tbl[6] = '{7'b0000000, {8'h0, 12'o7070}, 12, 7'b0000000, 0, {8'h0, 12'o7070}};
      tbl[7] = '{7'b0000001, 20'hfffff, 15, 7'b0000001, 3, 20'hfffff};
      tbl[8] = '{7'b0000000, 20'h0, 12, 7'b0000000, 0, 20'h0};

      repeat (3) @(negedge clk);
      check("reset_outs", {4'd0, keys_out, key_busy, sw_out}, 32'd0);
      #2 rst = 1'b0;
      repeat (8) @(negedge clk);
      #2;

      // Clean dep press: pulse after edges 6..8, busy from edge 6.
      raw_keys = 7'b0000100;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check($sformatf("dep_e%0d", k), dep, (k >= 6 && k <= 8));
         check($sformatf("dep_busy_e%0d", k), key_busy, (k >= 6));
         check($sformatf("dep_others_e%0d", k), keys_out & 7'b1111011, 0);
      end
      #2 raw_keys = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check($sformatf("rel_busy_e%0d", k), key_busy, (k < 6));
      end
      #2;

      for (int i = 0; i < 9; i++) begin
         raw_keys = tbl[i].rk;
         raw_sw   = tbl[i].rsw;
         run_cycles(tbl[i].cyc, seen, pc);
         check($sformatf("tbl%0d_seen", i), seen, tbl[i].exp_seen);
         check($sformatf("tbl%0d_pcyc", i), pc, tbl[i].exp_pcyc);
         check($sformatf("tbl%0d_sw", i), sw_out, tbl[i].exp_sw);
      end

      // Bouncing start contact.
      seen = '0;
      for (int c = 0; c < 30; c++) begin
         raw_keys = ((c / 2) % 2 == 0) ? 7'b0100000 : 7'b0000000;
         @(negedge clk);
         seen = seen | keys_out;
         #2;
      end
      raw_keys = '0;
      run_cycles(12, seen, pc);
      check("bounce_start_pcyc", pc, 0);

      // Exam held across reset.
      raw_keys = 7'b0001000;
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      run_cycles(15, seen, pc);
      check("exam_held_seen", seen, 0);
      check("exam_held_busy", key_busy, 1);
      raw_keys = '0;
      run_cycles(10, seen, pc);
      raw_keys = 7'b0001000;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check($sformatf("exam_e%0d", k), exam, (k >= 6 && k <= 8));
      end
      #2 raw_keys = '0;
      run_cycles(12, seen, pc);

      // Switch register with a glitching bit.
      raw_sw = {8'h0, 12'o7071};
      repeat (2) @(negedge clk);
      #2 raw_sw = {8'h0, 12'o7070};
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         check($sformatf("sr_e%0d", k), sr, (k >= 5) ? 12'o7070 : 12'o0000);
      end
      #2;

      // Reset in the second cycle of a load_addr pulse.
      raw_keys = 7'b0010000;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (load_addr) got = 1'b1;
      end
      check("la_rise", got, 1);
      @(negedge clk);
      check("la_second", load_addr, 1);
      #2 rst = 1'b1;
      #1;
      check("la_async_drop", {keys_out, key_busy}, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      run_cycles(20, seen, pc);
      check("la_after_rst_seen", seen, 0);
      check("la_after_rst_busy", key_busy, 1);
      raw_keys = '0;
      run_cycles(12, seen, pc);

      // Random stimulus against the model.
      left = 1500;
      while (left > 0) begin
         r = $urandom_range(0, 9);
         if (r < 4) raw_keys = '0;
         else if (r < 8) raw_keys = 7'(1) << $urandom_range(0, 6);
         else if (r == 8) raw_keys = (7'(1) << $urandom_range(0, 6)) | (7'(1) << $urandom_range(0, 6));
         else raw_keys = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 3) == 0) raw_sw = 20'($urandom);
         h = $urandom_range(1, 10);
         repeat (h) @(negedge clk);
         #2;
         left = left - h;
      end
      raw_keys = '0;
      run_cycles(12, seen, pc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
